// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared encodings for the unified-memory port arbiter: access sizes,
// transaction owner and arbiter FSM states.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter
// Saturating up-counter tracking consecutive D-grants taken while the
// I-port was waiting. Clear has priority over increment.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   inc          : increment (saturates at LIMIT)
//   clr          : clear to zero
//   cnt          : current count
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic at_limit;

    assign at_limit = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the fetch
// (I, read-only) and memory-stage (D, load/store) requesters. One
// transaction outstanding at a time. D has priority unless the I-port has
// been passed over STARVE_LIMIT times in a row while waiting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction outstanding; winner's request driven to memory
// ST_WAIT | request accepted; waiting for mem_resp_valid for the owner
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   i_req_* / i_resp_*           : fetch port request / response
//   d_req_* / d_resp_*           : data port request / response
//   mem_req_* / mem_resp_*       : shared memory request / response
//   err_spurious                 : sticky, unexpected response or size==3
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [1:0]        d_req_size,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [1:0]        mem_req_size,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              err_spurious
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e           state;
    owner_e           owner;
    logic             owner_store;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_full;
    logic             idle;
    logic             waiting;
    logic             d_wins;
    logic             accept;
    logic             resp_hit;

    // Gate with reset so every output reads 0 while reset is held.
    assign idle        = (state == ST_IDLE) && !reset;
    assign waiting     = (state == ST_WAIT) && !reset;
    assign starve_full = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign d_wins      = d_req_valid && !(starve_full && i_req_valid);

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_size  = '0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        if (idle && (i_req_valid || d_req_valid)) begin
            mem_req_valid = 1'b1;
            if (d_wins) begin
                mem_req_write = d_req_write;
                mem_req_size  = d_req_size;
                mem_req_addr  = d_req_addr;
                mem_req_wdata = d_req_wdata;
                d_req_ready   = mem_req_ready;
            end else begin
                mem_req_size  = SIZE_WORD;
                mem_req_addr  = i_req_addr;
                i_req_ready   = mem_req_ready;
            end
        end
    end

    assign accept = mem_req_valid && mem_req_ready;

    // Response routing: combinational from the memory, steered by owner.
    assign resp_hit     = waiting && mem_resp_valid;
    assign i_resp_valid = resp_hit && (owner == OWN_I);
    assign d_resp_valid = resp_hit && (owner == OWN_D);
    assign i_resp_data  = i_resp_valid ? mem_resp_data : '0;
    assign d_resp_data  = (d_resp_valid && !owner_store) ? mem_resp_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            owner        <= OWN_I;
            owner_store  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_resp_valid) begin
                        err_spurious <= 1'b1;
                    end
                    if (accept) begin
                        state       <= ST_WAIT;
                        owner       <= d_wins ? OWN_D : OWN_I;
                        owner_store <= d_wins && d_req_write;
                        if (d_wins && (d_req_size == SIZE_ILLEGAL)) begin
                            err_spurious <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (accept && d_wins && i_req_valid),
        .clr   (accept && !d_wins),
        .cnt   (starve_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbitration and routing rules.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid;
    logic        d_req_write;
    logic [1:0]  d_req_size;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        err_spurious;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_size(d_req_size),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_size(mem_req_size),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err_spurious(err_spurious)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_write = 0; d_req_size = 0; d_req_addr = 0; d_req_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    endtask

    initial begin
        bit dwin, any, acc, exp_d, outst, own_d, own_st;
        int starve, lat;

        // ---------------- reset state ----------------
        clr_in();
        reset = 1;
        i_req_valid = 1; mem_req_ready = 1;
        repeat (2) next();
        #2;
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_readies", {i_req_ready, d_req_ready}, 0);
        chk("rst_resp", {i_resp_valid, d_resp_valid}, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_cnt", dut.u_starve.cnt, 0);
        next();
        clr_in();
        reset = 0;

        // ---------------- I only, latency 3 ----------------
        i_req_valid = 1; i_req_addr = 32'h0100_0000; mem_req_ready = 1;
        #2;
        chk("i1_mem_valid", mem_req_valid, 1);
        chk("i1_ready", {i_req_ready, d_req_ready}, 2'b10);
        chk("i1_fields", {mem_req_write, mem_req_size, mem_req_addr, mem_req_wdata},
            {1'b0, 2'd2, 32'h0100_0000, 32'h0});
        next();
        i_req_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            mem_resp_valid = (k == 3);
            mem_resp_data  = 32'h1357_9BDF;
            #2;
            chk("i1_wait_req", {mem_req_valid, i_req_ready}, 0);
            chk("i1_resp_valid", i_resp_valid, (k == 3));
            chk("i1_d_resp", d_resp_valid, 0);
            if (k == 3) chk("i1_resp_data", i_resp_data, 32'h1357_9BDF);
            next();
        end
        mem_resp_valid = 0;

        // ---------------- simultaneous I + D store ----------------
        i_req_valid = 1; i_req_addr = 32'h0100_0004;
        d_req_valid = 1; d_req_write = 1; d_req_size = 2;
        d_req_addr = 32'h0100_0100; d_req_wdata = 32'hDEAD_BEEF;
        #2;
        chk("st_ready", {i_req_ready, d_req_ready}, 2'b01);
        chk("st_fields", {mem_req_write, mem_req_size, mem_req_addr, mem_req_wdata},
            {1'b1, 2'd2, 32'h0100_0100, 32'hDEAD_BEEF});
        next();
        d_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'hFFFF_FFFF;
        #2;
        chk("st_ack", {d_resp_valid, i_resp_valid}, 2'b10);
        chk("st_ack_data", d_resp_data, 0);
        chk("st_wait_iready", i_req_ready, 0);
        next();
        mem_resp_valid = 0;
        #2;
        chk("st_i_next", i_req_ready, 1);
        chk("st_i_fields", {mem_req_write, mem_req_addr, mem_req_wdata}, {1'b0, 32'h0100_0004, 32'h0});
        next();
        i_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h0BAD_F00D;
        #2;
        chk("st_i_resp", {i_resp_valid, i_resp_data}, {1'b1, 32'h0BAD_F00D});
        next();
        mem_resp_valid = 0;

        // ---------------- starvation pattern D,D,D,D,I ----------------
        i_req_valid = 1; i_req_addr = 32'h0100_0200;
        d_req_valid = 1; d_req_write = 0; d_req_size = 2; d_req_addr = 32'h0100_0300;
        mem_req_ready = 1;
        for (int k = 0; k < 10; k++) begin
            exp_d = (k % (LIMIT + 1)) != LIMIT;
            #2;
            chk("pat_grant", {d_req_ready, i_req_ready}, {exp_d, !exp_d});
            if (!exp_d) chk("pat_cnt_at_i", dut.u_starve.cnt, LIMIT);
            next();
            if (!exp_d) chk("pat_cnt_after_i", dut.u_starve.cnt, 0);
            mem_resp_valid = 1; mem_resp_data = k;
            #2;
            chk("pat_resp", {d_resp_valid, i_resp_valid}, {exp_d, !exp_d});
            next();
            mem_resp_valid = 0;
        end
        clr_in();

        // ---------------- spurious response in IDLE ----------------
        #2;
        chk("sp_err_before", err_spurious, 0);
        chk("sp_idle_fields", {mem_req_valid, mem_req_addr, mem_req_size}, 0);
        next();
        mem_resp_valid = 1; mem_resp_data = 32'hAAAA_5555;
        #2;
        chk("sp_no_resp", {i_resp_valid, d_resp_valid}, 0);
        next();
        mem_resp_valid = 0;
        repeat (3) next();
        chk("sp_err_sticky", err_spurious, 1);
        reset = 1;
        next();
        reset = 0;
        chk("sp_err_cleared", err_spurious, 0);

        // ---------------- reset while in WAIT ----------------
        i_req_valid = 1; i_req_addr = 32'h0100_0040; mem_req_ready = 1;
        #2;
        chk("rw_accept", i_req_ready, 1);
        next();
        i_req_valid = 0;
        reset = 1;
        next();
        reset = 0;
        next();
        next();
        mem_resp_valid = 1; mem_resp_data = 32'h1111_2222;
        #2;
        chk("rw_late_resp", {i_resp_valid, d_resp_valid}, 0);
        next();
        mem_resp_valid = 0;
        chk("rw_err", err_spurious, 1);
        i_req_valid = 1; i_req_addr = 32'h0100_0044;
        #2;
        chk("rw_new_accept", {mem_req_valid, i_req_ready}, 2'b11);
        next();
        i_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h3333_4444;
        #2;
        chk("rw_new_resp", {i_resp_valid, i_resp_data}, {1'b1, 32'h3333_4444});
        next();
        mem_resp_valid = 0;

        // ---------------- withdrawn I request ----------------
        i_req_valid = 1; i_req_addr = 32'h0100_0080;
        d_req_valid = 1; d_req_write = 0; d_req_size = 0; d_req_addr = 32'h0100_0090;
        #2;
        chk("wd_d_first", d_req_ready, 1);
        next();
        d_req_valid = 0;
        mem_resp_valid = 1; mem_resp_data = 32'h55;
        next();
        mem_resp_valid = 0;
        chk("wd_cnt_one", dut.u_starve.cnt, 1);
        mem_req_ready = 0;
        #2;
        chk("wd_i_offered", {mem_req_valid, i_req_ready, mem_req_addr}, {2'b10, 32'h0100_0080});
        next();
        i_req_valid = 0;
        d_req_valid = 1; d_req_addr = 32'h0100_00A0; mem_req_ready = 1;
        #2;
        chk("wd_d_issue", {d_req_ready, mem_req_addr}, {1'b1, 32'h0100_00A0});
        next();
        d_req_valid = 0;
        chk("wd_cnt_hold", dut.u_starve.cnt, 1);
        mem_resp_valid = 1; mem_resp_data = 32'h6677_8899;
        #2;
        chk("wd_d_resp", {d_resp_valid, i_resp_valid, d_resp_data}, {2'b10, 32'h6677_8899});
        next();
        clr_in();

        // ---------------- illegal size forwarded, sets error ----------------
        reset = 1;
        next();
        reset = 0;
        d_req_valid = 1; d_req_size = 3; d_req_addr = 32'h0100_0010; mem_req_ready = 1;
        #2;
        chk("sz3_fwd", {d_req_ready, mem_req_size}, {1'b1, 2'd3});
        next();
        d_req_valid = 0;
        chk("sz3_err", err_spurious, 1);
        mem_resp_valid = 1; mem_resp_data = 32'hCAFE_0003;
        #2;
        chk("sz3_resp", {d_resp_valid, d_resp_data}, {1'b1, 32'hCAFE_0003});
        next();
        clr_in();

        // ---------------- randomized run against model ----------------
        starve = 0; outst = 0; own_d = 0; own_st = 0; lat = 0;
        for (int c = 0; c < 400; c++) begin
            if (!i_req_valid && $urandom_range(0, 2) == 0) begin
                i_req_valid = 1;
                i_req_addr  = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req_valid && $urandom_range(0, 2) == 0) begin
                d_req_valid = 1;
                d_req_write = 1'($urandom_range(0, 1));
                d_req_size  = 2'($urandom_range(0, 2));
                d_req_addr  = $urandom;
                d_req_wdata = $urandom;
            end
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = outst && (lat == 0);
            mem_resp_data  = $urandom;
            #2;
            if (outst) begin
                chk("rnd_wait_req", {mem_req_valid, i_req_ready, d_req_ready}, 0);
                chk("rnd_resp_route", {i_resp_valid, d_resp_valid},
                    {mem_resp_valid && !own_d, mem_resp_valid && own_d});
                if (mem_resp_valid && !own_d) chk("rnd_i_data", i_resp_data, mem_resp_data);
                if (mem_resp_valid && own_d)
                    chk("rnd_d_data", d_resp_data, own_st ? 32'h0 : mem_resp_data);
                next();
                if (mem_resp_valid) outst = 0;
                else lat--;
            end else begin
                any  = i_req_valid || d_req_valid;
                dwin = d_req_valid && !(starve == LIMIT && i_req_valid);
                acc  = any && mem_req_ready;
                chk("rnd_mvalid", mem_req_valid, any);
                chk("rnd_grant", {d_req_ready, i_req_ready}, {acc && dwin, acc && !dwin});
                chk("rnd_no_resp", {i_resp_valid, d_resp_valid}, 0);
                if (any)
                    chk("rnd_fields", {mem_req_write, mem_req_size, mem_req_addr, mem_req_wdata},
                        dwin ? {d_req_write, d_req_size, d_req_addr, d_req_wdata}
                             : {1'b0, 2'd2, i_req_addr, 32'h0});
                next();
                if (acc) begin
                    outst  = 1;
                    lat    = $urandom_range(0, 3);
                    own_d  = dwin;
                    own_st = dwin && d_req_write;
                    if (dwin) begin
                        if (i_req_valid && starve < LIMIT) starve++;
                        d_req_valid = 0;
                    end else begin
                        starve = 0;
                        i_req_valid = 0;
                    end
                end
            end
        end
        clr_in();
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch-stage instruction requester (I-port, read-only) and the memory-stage data requester (D-port, load/store).
- Sits between the pipeline core and the memory model; replaces the separate instruction and data memory instances.
- Allows one outstanding transaction at a time. The memory has variable latency.
- The core derives its fetch and memory stalls from the per-port valid/ready/resp handshakes.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- STARVE_LIMIT, 4, consecutive D-grants while the I-port waits before the I-port is forced to win; must be ≥1

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  fetch request pending
- i_req_addr  in  ADDR_W  fetch address (word access)
- i_req_ready  out  1  fetch request accepted this cycle
- i_resp_valid  out  1  fetch data valid, one-cycle pulse
- i_resp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  data request pending
- d_req_write  in  1  0 = load, 1 = store
- d_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  load data or store ack, one-cycle pulse
- d_resp_data  out  DATA_W  raw load data; zero for stores
- mem_req_valid  out  1  request to memory
- mem_req_write  out  1  write enable
- mem_req_size  out  2  access size
- mem_req_addr  out  ADDR_W  address
- mem_req_wdata  out  DATA_W  write data
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  memory response, one-cycle pulse; stores are also acked
- mem_resp_data  in  DATA_W  read data
- err_spurious  out  1  sticky: a response arrived with no outstanding request, or d_req_size==3 was accepted

Behaviour:
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - owner cleared
  - starve counter 0
  - err_spurious 0
- FSM has two states, IDLE and WAIT.
- IDLE:
  - mem_req_valid = i_req_valid | d_req_valid, combinational.
  - The winner is selected combinationally:
    - D wins when d_req_valid, unless (starve_cnt == STARVE_LIMIT and i_req_valid).
    - Otherwise I wins.
  - The mem_req_* fields are muxed from the winner.
  - I-port requests drive write=0, size=2, wdata=0.
  - With no valid request, mem_req_* fields are 0.
- Accept: when mem_req_valid & mem_req_ready in IDLE:
  - the winner's *_req_ready is 1 in the same cycle, and the loser's stays 0;
  - the owner is latched;
  - the next state is WAIT.
- WAIT:
  - mem_req_valid = 0 and both req_ready = 0.
  - On mem_resp_valid, the owner's resp_valid pulses high for exactly that cycle, with resp_data = mem_resp_data.
  - d_resp_data is forced to 0 when the owner's request was a store.
  - The next state is IDLE.
  - The earliest next request is issued in the following cycle: minimum throughput is one transaction per 2 cycles, with a zero-latency memory response arriving in the cycle after accept.
- Response routing is purely combinational from mem_resp_*, gated by the state and owner registers.
- Starve counter (updated at accept):
  - D accepted while i_req_valid: increment, saturating at STARVE_LIMIT.
  - I accepted: clear to 0.
  - Otherwise: hold.
- Requesters must hold valid and all fields stable until their ready is seen. Deasserting valid before accept is allowed; such a request is simply not issued.
- A response in IDLE, i.e. with no outstanding request, is dropped with no resp_valid pulse, and err_spurious is set.
- An accepted d_req_size==3 is still forwarded unchanged, and err_spurious is set.
- err_spurious clears only on reset.
- Reset mid-transaction (in WAIT):
  - returns to IDLE next cycle;
  - the outstanding response is abandoned;
  - a late mem_resp_valid after reset is treated as spurious.
- If both ports are valid every cycle and the memory is always ready, the grant pattern repeats STARVE_LIMIT D-grants followed by 1 I-grant.

Decomposition:
- Shared pipeline package holds:
  - the size encodings (SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2);
  - the owner encoding (OWN_I = 0, OWN_D = 1);
  - the FSM state encoding.
- One natural sub-module, arb_starve_counter: saturating counter with inc/clr/limit. The FSM, muxing and routing remain in the top level.

Test Plan:
- Only the I-port, addr 0x01000000, memory latency 3 → i_req_ready in the accept cycle, i_resp_valid exactly 3 cycles later carrying the memory word, d_resp_valid never set.
- I and D both valid in the same IDLE cycle, D = store word 0xDEADBEEF to 0x01000100 → D granted first with mem_req_write=1, size=2; d_resp_valid ack with d_resp_data=0; I granted in the next IDLE cycle.
- Both ports continuously valid, STARVE_LIMIT=4, memory latency 1 → accepted owner sequence D,D,D,D,I repeating; the counter reads 4 at each I-grant and 0 after it.
- Unsolicited mem_resp_valid pulse in IDLE → no resp_valid on either port; err_spurious=1 and stays 1 until reset.
- Reset asserted while in WAIT, memory response arrives 2 cycles after reset deasserts → no resp_valid; err_spurious=1; a new I request is accepted normally.
- I request withdrawn before mem_req_ready, then D request issued → no I transaction reaches memory; D completes; starve counter unchanged by the withdrawn request.
